stdp_pair: RTL and testbench

- Parametrised pre/post LIF neuron pair joined by one plastic synapse, with on-chip STDP weight learning.
- The pre neuron is driven by an external current. The post neuron is driven by an external current plus the synaptic weight, gated by the pre spike.
- Spike-timing counters set the size of potentiation/depression. The weight saturates in [0, WMAX].
- Sits between the tile input pins and the spike/state/weight output pins, replacing the fixed-width, non-learning neuron pair.

---
 rtl/stdp_pkg.sv | 34 +++
 rtl/lif_neuron.sv | 57 +++++
 rtl/stdp_pair.sv | 98 +++++++++
 tb/tb_stdp_pair.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared defaults and saturating arithmetic for the STDP neuron pair.
// The helpers work on 32-bit operands, so W and WW must not exceed 32.
package stdp_pkg;

    localparam int W_DEF          = 8;
    localparam int THRESHOLD_DEF  = 200;
    localparam int LEAK_SHIFT_DEF = 3;
    localparam int REFRAC_DEF     = 2;
    localparam int WW_DEF         = 8;
    localparam int W_INIT_DEF     = 64;
    localparam int WMAX_DEF       = 255;
    localparam int A_LTP_DEF      = 16;
    localparam int A_LTD_DEF      = 12;
    localparam int WINDOW_DEF     = 32;
    localparam int TAU_SHIFT_DEF  = 2;

    function automatic int dt_width(input int window);
        return $clog2(window + 1);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] limit);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, limit}) ? limit : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with refractory period and registered spike.
// fire_o is the next-state spike, so timers can be loaded on the spiking edge.
module lif_neuron
    import stdp_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int THRESHOLD  = THRESHOLD_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRAC     = REFRAC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cur_i,
    output logic         fire_o,
    output logic         spike_o,
    output logic [W-1:0] state_o
);

    localparam int          RW        = $clog2(REFRAC + 2);
    localparam logic [31:0] STATE_MAX = 32'((64'd1 << W) - 64'd1);

    logic [W-1:0]  state_q, state_d, sum;
    logic [RW-1:0] refrac_q, refrac_d;
    logic          spike_q, spike_d;

    always_comb begin
        sum      = W'(sat_add(32'(state_q - (state_q >> LEAK_SHIFT)), 32'(cur_i), STATE_MAX));
        state_d  = sum;
        refrac_d = refrac_q;
        spike_d  = 1'b0;
        if (refrac_q != '0) begin
            state_d  = '0;
            refrac_d = refrac_q - RW'(1);
        end else if (32'(sum) >= 32'(THRESHOLD)) begin
            spike_d  = 1'b1;
            state_d  = '0;
            refrac_d = RW'(REFRAC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= '0;
            refrac_q <= '0;
            spike_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            refrac_q <= refrac_d;
            spike_q  <= spike_d;
        end
    end

    assign fire_o  = spike_d;
    assign spike_o = spike_q;
    assign state_o = state_q;

endmodule

// File: rtl/stdp_pair.sv
// Pre/post LIF neuron pair joined by one plastic synapse with STDP learning.
// Learning looks at the registered spikes and the timer values from before the edge.
module stdp_pair
    import stdp_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int THRESHOLD  = THRESHOLD_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRAC     = REFRAC_DEF,
    parameter int WW         = WW_DEF,
    parameter int W_INIT     = W_INIT_DEF,
    parameter int WMAX       = WMAX_DEF,
    parameter int A_LTP      = A_LTP_DEF,
    parameter int A_LTD      = A_LTD_DEF,
    parameter int WINDOW     = WINDOW_DEF,
    parameter int TAU_SHIFT  = TAU_SHIFT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  cur_pre,
    input  logic [W-1:0]  cur_post,
    input  logic          learn_en,
    output logic          spike_pre,
    output logic          spike_post,
    output logic [W-1:0]  state_pre,
    output logic [W-1:0]  state_post,
    output logic [WW-1:0] weight,
    output logic          ltp,
    output logic          ltd
);

    localparam int              DT_W   = dt_width(WINDOW);
    localparam logic [DT_W-1:0] DT_SAT = DT_W'(WINDOW);
    localparam logic [31:0]     CUR_MAX = 32'((64'd1 << W) - 64'd1);

    logic [W-1:0]    cur_post_eff;
    logic            fire_pre, fire_post;
    logic [DT_W-1:0] dt_pre_q, dt_pre_d, dt_post_q, dt_post_d;
    logic [WW-1:0]   weight_q, weight_d;
    logic [31:0]     ltp_step, ltd_step;
    logic            ltp_q, ltp_d, ltd_q, ltd_d;

    // Registered pre spike gates the weight, giving one cycle of pre-to-post latency.
    assign cur_post_eff = W'(sat_add(32'(cur_post), spike_pre ? 32'(weight_q) : 32'd0, CUR_MAX));

    lif_neuron #(
        .W(W), .THRESHOLD(THRESHOLD), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
    ) u_pre (
        .clk(clk), .rst(rst), .cur_i(cur_pre),
        .fire_o(fire_pre), .spike_o(spike_pre), .state_o(state_pre)
    );

    lif_neuron #(
        .W(W), .THRESHOLD(THRESHOLD), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
    ) u_post (
        .clk(clk), .rst(rst), .cur_i(cur_post_eff),
        .fire_o(fire_post), .spike_o(spike_post), .state_o(state_post)
    );

    always_comb begin
        dt_pre_d  = fire_pre  ? '0 : ((dt_pre_q  == DT_SAT) ? DT_SAT : dt_pre_q  + DT_W'(1));
        dt_post_d = fire_post ? '0 : ((dt_post_q == DT_SAT) ? DT_SAT : dt_post_q + DT_W'(1));
        ltp_step  = 32'(A_LTP) >> (dt_pre_q  >> TAU_SHIFT);
        ltd_step  = 32'(A_LTD) >> (dt_post_q >> TAU_SHIFT);
        weight_d  = weight_q;
        ltp_d     = 1'b0;
        ltd_d     = 1'b0;
        // Coincident spikes fall through both branches and leave the weight alone.
        if (learn_en && spike_post && !spike_pre && (dt_pre_q < DT_SAT)) begin
            weight_d = WW'(sat_add(32'(weight_q), ltp_step, 32'(WMAX)));
            ltp_d    = 1'b1;
        end else if (learn_en && spike_pre && !spike_post && (dt_post_q < DT_SAT)) begin
            weight_d = WW'(sat_sub(32'(weight_q), ltd_step));
            ltd_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_pre_q  <= DT_SAT;
            dt_post_q <= DT_SAT;
            weight_q  <= WW'(W_INIT);
            ltp_q     <= 1'b0;
            ltd_q     <= 1'b0;
        end else begin
            dt_pre_q  <= dt_pre_d;
            dt_post_q <= dt_post_d;
            weight_q  <= weight_d;
            ltp_q     <= ltp_d;
            ltd_q     <= ltd_d;
        end
    end

    assign weight = weight_q;
    assign ltp    = ltp_q;
    assign ltd    = ltd_q;

endmodule

// File: tb/tb_stdp_pair.sv
// Directed bench for stdp_pair: a per-edge vector table for integration and
// pairing, then hand-written sequences for windows, saturation and reset.
module tb_stdp_pair;

    typedef struct {
        logic [7:0] curPre;
        logic [7:0] curPost;
        logic       learnEn;
        logic       spikePre;
        logic       spikePost;
        logic [7:0] statePre;
        logic [7:0] statePost;
        logic [7:0] weight;
        logic       ltp;
        logic       ltd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] curPre = '0;
    logic [7:0] curPost = '0;
    logic       learnEn = 1'b1;
    logic       spikePre, spikePost, ltpPulse, ltdPulse;
    logic [7:0] statePre, statePost, weight;

    int vecCount  = 0;
    int missCount = 0;
    vec_t vecs[12];

    stdp_pair dut (
        .clk(clk), .rst(rst), .cur_pre(curPre), .cur_post(curPost), .learn_en(learnEn),
        .spike_pre(spikePre), .spike_post(spikePost), .state_pre(statePre),
        .state_post(statePost), .weight(weight), .ltp(ltpPulse), .ltd(ltdPulse)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] p, input logic [7:0] q);
        curPre  = p;
        curPost = q;
        stepClk();
    endtask

    task automatic doReset();
        curPre  = '0;
        curPost = '0;
        learnEn = 1'b1;
        rst     = 1'b1;
        stepClk();
        rst     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(8'd0, 8'd0);
    endtask

    // Pre spike, then post spike k edges later; returns just after the learning edge.
    task automatic pairLtp(input int k);
        applyStimulus(8'd255, 8'd0);
        repeat (k - 1) applyStimulus(8'd0, 8'd0);
        applyStimulus(8'd0, 8'd255);
        applyStimulus(8'd0, 8'd0);
    endtask

    // Post spike, then pre spike k edges later; returns just after the learning edge.
    task automatic pairLtd(input int k);
        applyStimulus(8'd0, 8'd255);
        repeat (k - 1) applyStimulus(8'd0, 8'd0);
        applyStimulus(8'd255, 8'd0);
        applyStimulus(8'd0, 8'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           curPre  curPost en  spP   spQ   stP     stQ     wt      ltp   ltd
        vecs[0]  = '{8'd64,  8'd0,   1, 1'b0, 1'b0, 8'd64,  8'd0,   8'd64,  1'b0, 1'b0};
        vecs[1]  = '{8'd64,  8'd0,   1, 1'b0, 1'b0, 8'd120, 8'd0,   8'd64,  1'b0, 1'b0};
        vecs[2]  = '{8'd64,  8'd0,   1, 1'b0, 1'b0, 8'd169, 8'd0,   8'd64,  1'b0, 1'b0};
        vecs[3]  = '{8'd64,  8'd0,   1, 1'b1, 1'b0, 8'd0,   8'd0,   8'd64,  1'b0, 1'b0};
        vecs[4]  = '{8'd64,  8'd0,   1, 1'b0, 1'b0, 8'd0,   8'd64,  8'd64,  1'b0, 1'b0};
        vecs[5]  = '{8'd64,  8'd0,   1, 1'b0, 1'b0, 8'd0,   8'd56,  8'd64,  1'b0, 1'b0};
        vecs[6]  = '{8'd64,  8'd0,   1, 1'b0, 1'b0, 8'd64,  8'd49,  8'd64,  1'b0, 1'b0};
        vecs[7]  = '{8'd64,  8'd0,   1, 1'b0, 1'b0, 8'd120, 8'd43,  8'd64,  1'b0, 1'b0};
        vecs[8]  = '{8'd64,  8'd255, 1, 1'b0, 1'b1, 8'd169, 8'd0,   8'd64,  1'b0, 1'b0};
        vecs[9]  = '{8'd64,  8'd0,   1, 1'b1, 1'b0, 8'd0,   8'd0,   8'd72,  1'b1, 1'b0};
        vecs[10] = '{8'd0,   8'd0,   1, 1'b0, 1'b0, 8'd0,   8'd0,   8'd60,  1'b0, 1'b1};
        vecs[11] = '{8'd0,   8'd0,   1, 1'b0, 1'b0, 8'd0,   8'd0,   8'd60,  1'b0, 1'b0};

        doReset();
        checkOutput("reset spike_pre", 32'(spikePre), 32'd0);
        checkOutput("reset spike_post", 32'(spikePost), 32'd0);
        checkOutput("reset state_pre", 32'(statePre), 32'd0);
        checkOutput("reset weight", 32'(weight), 32'd64);
        checkOutput("reset pulses", 32'({ltpPulse, ltdPulse}), 32'd0);

        // Integration run: pre charges to a spike, then a post spike 5 edges later
        // potentiates and the following pre spike depresses.
        for (int i = 0; i < 12; i++) begin
            learnEn = vecs[i].learnEn;
            applyStimulus(vecs[i].curPre, vecs[i].curPost);
            vecCount++;
            if ({spikePre, spikePost, statePre, statePost, weight, ltpPulse, ltdPulse} !==
                {vecs[i].spikePre, vecs[i].spikePost, vecs[i].statePre, vecs[i].statePost,
                 vecs[i].weight, vecs[i].ltp, vecs[i].ltd}) begin
                missCount++;
                $display("[TB] FAIL vec%0d: got sp=%0b sq=%0b stp=%0d stq=%0d w=%0d ltp=%0b ltd=%0b, expected sp=%0b sq=%0b stp=%0d stq=%0d w=%0d ltp=%0b ltd=%0b",
                         i, spikePre, spikePost, statePre, statePost, weight, ltpPulse, ltdPulse,
                         vecs[i].spikePre, vecs[i].spikePost, vecs[i].statePre, vecs[i].statePost,
                         vecs[i].weight, vecs[i].ltp, vecs[i].ltd);
            end
        end

        doReset();
        pairLtp(3);
        checkOutput("ltp dt3 weight", 32'(weight), 32'd80);
        checkOutput("ltp dt3 pulse", 32'(ltpPulse), 32'd1);
        stepClk();
        checkOutput("ltp pulse one cycle", 32'(ltpPulse), 32'd0);

        doReset();
        pairLtp(9);
        checkOutput("ltp dt9 weight", 32'(weight), 32'd68);

        doReset();
        pairLtp(31);
        checkOutput("ltp zero step weight", 32'(weight), 32'd64);
        checkOutput("ltp zero step pulse", 32'(ltpPulse), 32'd1);

        doReset();
        pairLtd(5);
        checkOutput("ltd dt5 weight", 32'(weight), 32'd58);
        checkOutput("ltd dt5 pulse", 32'(ltdPulse), 32'd1);

        doReset();
        pairLtd(40);
        checkOutput("ltd outside window weight", 32'(weight), 32'd64);
        checkOutput("ltd outside window pulse", 32'(ltdPulse), 32'd0);

        // Climb to 250 (+2, +8, then 11 x +16), then saturate at 255.
        doReset();
        pairLtp(12);
        checkOutput("ltp dt12 weight", 32'(weight), 32'd66);
        idle(40);
        pairLtp(4);
        idle(40);
        for (int n = 0; n < 11; n++) begin
            pairLtp(1);
            idle(40);
        end
        checkOutput("ltp climb weight", 32'(weight), 32'd250);
        pairLtp(1);
        checkOutput("ltp saturate weight", 32'(weight), 32'd255);
        checkOutput("ltp saturate pulse", 32'(ltpPulse), 32'd1);

        // Descend to 5 (4 x -12, -6, -3, 2 x -1), then clamp at 0.
        doReset();
        for (int n = 0; n < 4; n++) begin
            pairLtd(1);
            idle(40);
        end
        pairLtd(5);
        idle(40);
        pairLtd(9);
        idle(40);
        pairLtd(13);
        idle(40);
        pairLtd(13);
        idle(40);
        checkOutput("ltd descend weight", 32'(weight), 32'd5);
        pairLtd(1);
        checkOutput("ltd saturate weight", 32'(weight), 32'd0);
        checkOutput("ltd saturate pulse", 32'(ltdPulse), 32'd1);

        doReset();
        applyStimulus(8'd255, 8'd255);
        checkOutput("simul both spikes", 32'({spikePre, spikePost}), 32'd3);
        applyStimulus(8'd0, 8'd0);
        checkOutput("simul weight", 32'(weight), 32'd64);
        checkOutput("simul pulses", 32'({ltpPulse, ltdPulse}), 32'd0);

        doReset();
        learnEn = 1'b0;
        pairLtp(3);
        checkOutput("learn off weight", 32'(weight), 32'd64);
        checkOutput("learn off pulse", 32'(ltpPulse), 32'd0);

        // Asynchronous reset between edges while pre is refractory and timers run.
        doReset();
        pairLtp(3);
        idle(40);
        applyStimulus(8'd255, 8'd100);
        checkOutput("pre-reset spike_pre", 32'(spikePre), 32'd1);
        checkOutput("pre-reset state_post", 32'(statePost), 32'd100);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset spike_pre", 32'(spikePre), 32'd0);
        checkOutput("async reset state_post", 32'(statePost), 32'd0);
        checkOutput("async reset weight", 32'(weight), 32'd64);
        #1;
        rst = 1'b0;
        applyStimulus(8'd64, 8'd0);
        checkOutput("post-reset state_pre", 32'(statePre), 32'd64);
        checkOutput("post-reset weight", 32'(weight), 32'd64);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
